// File: rtl/signed_cmp_bist.sv
// Built-in self test for a 4-bit signed magnitude comparator with cascade inputs.
// Drives all 256 operand pairs, checks the three result flags and records errors.
module signed_cmp_bist #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] a_ip,
  output logic [3:0] b_ip,
  output logic       a_ip_G,
  output logic       b_ip_G,
  output logic       a_ip_E_b,
  input  logic       a_op_G,
  input  logic       a_op_E_b,
  input  logic       b_op_G,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_cnt,
  output logic       fail_vld,
  output logic [3:0] fail_a,
  output logic [3:0] fail_b,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    APPLY = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [7:0] idx;
  logic [3:0] settle_cnt;
  logic [2:0] exp_res;
  logic       vec_err;
  logic [8:0] err_next;

  // Cascade inputs make the device behave as a standalone (least significant) stage.
  assign a_ip_G    = 1'b0;
  assign b_ip_G    = 1'b0;
  assign a_ip_E_b  = 1'b1;
  assign state_dbg = state;

  always_comb begin
    exp_res = 3'b001;
    if ($signed(a_ip) > $signed(b_ip)) exp_res = 3'b100;
    else if (a_ip == b_ip)             exp_res = 3'b010;
  end

  // Any pattern other than the single expected flag (including 000 or 110) is an error.
  assign vec_err  = ({a_op_G, a_op_E_b, b_op_G} != exp_res);
  assign err_next = (vec_err && (err_cnt != 9'd256)) ? err_cnt + 9'd1 : err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 8'd0;
      settle_cnt <= 4'd0;
      a_ip       <= 4'd0;
      b_ip       <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= 9'd0;
      fail_vld   <= 1'b0;
      fail_a     <= 4'd0;
      fail_b     <= 4'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= APPLY;
            idx      <= 8'd0;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= 9'd0;
            fail_vld <= 1'b0;
            fail_a   <= 4'd0;
            fail_b   <= 4'd0;
          end
        end
        APPLY: begin
          a_ip       <= idx[3:0];
          b_ip       <= idx[7:4];
          settle_cnt <= 4'd0;
          state      <= WAIT;
        end
        WAIT: begin
          if (settle_cnt == SETTLE_LAST) state <= CHECK;
          else                           settle_cnt <= settle_cnt + 4'd1;
        end
        CHECK: begin
          err_cnt <= err_next;
          if (vec_err && !fail_vld) begin
            fail_vld <= 1'b1;
            fail_a   <= a_ip;
            fail_b   <= b_ip;
          end
          // pass uses err_next so the final vector's verdict is included.
          if (idx == 8'hFF) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 9'd0);
          end else begin
            idx   <= idx + 8'd1;
            state <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_cmp_bist.sv
// Bench for signed_cmp_bist: two instances (SETTLE=1 and SETTLE=3) driving
// behavioural comparator models, with per-sweep results scoreboarded on done.
module tb_signed_cmp_bist;

  localparam int W = 35; // {cycles[15:0], err[8:0], pass, fail_vld, fail_a[3:0], fail_b[3:0]}
  localparam logic [2:0] ST_IDLE = 3'd0, ST_DONE = 3'd4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0, start3 = 1'b0;
  int   mode = 0; // 0 ideal, 1 a_op_G stuck 0, 2 unsigned, 3 three-cycle delay

  int n_tests = 0, n_fail = 0;
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q3[$];

  logic [3:0] a_ip1, b_ip1, fail_a1, fail_b1, a_ip3, b_ip3, fail_a3, fail_b3;
  logic       a_ip_G1, b_ip_G1, a_ip_E_b1, a_ip_G3, b_ip_G3, a_ip_E_b3;
  logic       busy1, done1, pass1, fail_vld1, busy3, done3, pass3, fail_vld3;
  logic [8:0] err_cnt1, err_cnt3;
  logic [2:0] state1, state3, res1, res3;
  logic [2:0] d1_1 = 3'b010, d2_1 = 3'b010, d3_1 = 3'b010;
  logic [2:0] d1_3 = 3'b010, d2_3 = 3'b010, d3_3 = 3'b010;

  always #5 clk = ~clk;

  // ---------------- comparator models ----------------
  function automatic logic [2:0] ideal_cmp(input logic [3:0] a, input logic [3:0] b);
    if ($signed(a) > $signed(b)) return 3'b100;
    if (a == b)                  return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [2:0] unsigned_cmp(input logic [3:0] a, input logic [3:0] b);
    if (a > b)  return 3'b100;
    if (a == b) return 3'b010;
    return 3'b001;
  endfunction

  always @(posedge clk) begin
    d1_1 <= ideal_cmp(a_ip1, b_ip1); d2_1 <= d1_1; d3_1 <= d2_1;
    d1_3 <= ideal_cmp(a_ip3, b_ip3); d2_3 <= d1_3; d3_3 <= d2_3;
  end

  always_comb begin
    res1 = ideal_cmp(a_ip1, b_ip1);
    case (mode)
      1: res1 = ideal_cmp(a_ip1, b_ip1) & 3'b011;
      2: res1 = unsigned_cmp(a_ip1, b_ip1);
      3: res1 = d3_1;
      default: ;
    endcase
  end
  assign res3 = d3_3;

  signed_cmp_bist #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_ip(a_ip1), .b_ip(b_ip1),
    .a_ip_G(a_ip_G1), .b_ip_G(b_ip_G1), .a_ip_E_b(a_ip_E_b1),
    .a_op_G(res1[2]), .a_op_E_b(res1[1]), .b_op_G(res1[0]),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err_cnt1),
    .fail_vld(fail_vld1), .fail_a(fail_a1), .fail_b(fail_b1), .state_dbg(state1));

  signed_cmp_bist #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a_ip(a_ip3), .b_ip(b_ip3),
    .a_ip_G(a_ip_G3), .b_ip_G(b_ip_G3), .a_ip_E_b(a_ip_E_b3),
    .a_op_G(res3[2]), .a_op_E_b(res3[1]), .b_op_G(res3[0]),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err_cnt3),
    .fail_vld(fail_vld3), .fail_a(fail_a3), .fail_b(fail_b3), .state_dbg(state3));

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] make_exp(input int cyc, input int err, input logic ps,
                                            input logic fv, input logic [3:0] fa, input logic [3:0] fb);
    return {16'(cyc), 9'(err), ps, fv, fa, fb};
  endfunction

  task automatic check_sweep(input string tag, input logic [W-1:0] e, input int cyc,
                             input logic [8:0] err, input logic ps, input logic fv,
                             input logic [3:0] fa, input logic [3:0] fb);
    check({tag, "_cycles"},   32'(cyc), 32'(e[34:19]));
    check({tag, "_err_cnt"},  32'(err), 32'(e[18:10]));
    check({tag, "_pass"},     32'(ps),  32'(e[9]));
    check({tag, "_fail_vld"}, 32'(fv),  32'(e[8]));
    check({tag, "_fail_a"},   32'(fa),  32'(e[7:4]));
    check({tag, "_fail_b"},   32'(fb),  32'(e[3:0]));
  endtask

  task automatic check_reset1(input string tag);
    check({tag, "_a_ip"},     32'(a_ip1),     32'h0);
    check({tag, "_b_ip"},     32'(b_ip1),     32'h0);
    check({tag, "_busy"},     32'(busy1),     32'h0);
    check({tag, "_done"},     32'(done1),     32'h0);
    check({tag, "_pass"},     32'(pass1),     32'h0);
    check({tag, "_err_cnt"},  32'(err_cnt1),  32'h0);
    check({tag, "_fail_vld"}, 32'(fail_vld1), 32'h0);
    check({tag, "_fail_a"},   32'(fail_a1),   32'h0);
    check({tag, "_fail_b"},   32'(fail_b1),   32'h0);
    check({tag, "_state"},    32'(state1),    32'(ST_IDLE));
    check({tag, "_cascade"},  32'({a_ip_G1, b_ip_G1, a_ip_E_b1}), 32'b001);
  endtask

  // ---------------- monitors: pop expected sweep result on done rising ----------------
  int   cyc1 = 0, cyc3 = 0;
  logic done1_q = 1'b0, done3_q = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      cyc1 = 0; done1_q = 1'b0;
    end else begin
      if (done1 && !done1_q) begin
        if (exp_q1.size() == 0) check("dut1_unexpected_done", 32'(done1), 32'h0);
        else check_sweep("dut1", exp_q1.pop_front(), cyc1, err_cnt1, pass1, fail_vld1, fail_a1, fail_b1);
        cyc1 = 0;
      end else if (busy1) cyc1++;
      done1_q = done1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      cyc3 = 0; done3_q = 1'b0;
    end else begin
      if (done3 && !done3_q) begin
        if (exp_q3.size() == 0) check("dut3_unexpected_done", 32'(done3), 32'h0);
        else check_sweep("dut3", exp_q3.pop_front(), cyc3, err_cnt3, pass3, fail_vld3, fail_a3, fail_b3);
        cyc3 = 0;
      end else if (busy3) cyc3++;
      done3_q = done3;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start1();
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
  endtask

  task automatic wait_q1(input int budget);
    int n = 0;
    while (exp_q1.size() != 0 && n < budget) begin @(negedge clk); n++; end
    if (exp_q1.size() != 0) begin
      check("dut1_sweep_timeout", 32'(exp_q1.size()), 32'h0);
      exp_q1.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_q3(input int budget);
    int n = 0;
    while (exp_q3.size() != 0 && n < budget) begin @(negedge clk); n++; end
    if (exp_q3.size() != 0) begin
      check("dut3_sweep_timeout", 32'(exp_q3.size()), 32'h0);
      exp_q3.delete();
    end
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset1("por");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_no_autostart_busy", 32'(busy1), 32'h0);
    check("idle_no_autostart_state", 32'(state1), 32'(ST_IDLE));

    // Ideal comparator; a second start mid-sweep must be ignored.
    mode = 0;
    exp_q1.push_back(make_exp(768, 0, 1'b1, 1'b0, 4'h0, 4'h0));
    pulse_start1();
    check("start_busy", 32'(busy1), 32'h1);
    repeat (100) @(negedge clk);
    pulse_start1();
    wait_q1(2000);
    check("done_a_ip_last", 32'(a_ip1), 32'hF);
    check("done_b_ip_last", 32'(b_ip1), 32'hF);
    check("done_busy", 32'(busy1), 32'h0);
    check("done_state", 32'(state1), 32'(ST_DONE));
    check("done_cascade", 32'({a_ip_G1, b_ip_G1, a_ip_E_b1}), 32'b001);

    // a_op_G stuck at 0: 120 vectors with A>B fail, first at A=1,B=0.
    mode = 1;
    exp_q1.push_back(make_exp(768, 120, 1'b0, 1'b1, 4'h1, 4'h0));
    pulse_start1();
    check("restart_done_cleared", 32'(done1), 32'h0);
    check("restart_pass_cleared", 32'(pass1), 32'h0);
    wait_q1(2000);

    // Unsigned comparator: 128 mixed-sign vectors fail, first at A=8,B=0.
    mode = 2;
    exp_q1.push_back(make_exp(768, 128, 1'b0, 1'b1, 4'h8, 4'h0));
    pulse_start1();
    check("restart_err_cleared", 32'(err_cnt1), 32'h0);
    check("restart_fail_vld_cleared", 32'(fail_vld1), 32'h0);
    wait_q1(2000);

    // Three-cycle-delay comparator sampled too early: each vector sees its
    // predecessor's result; 45 class changes along the sweep order.
    mode = 3;
    exp_q1.push_back(make_exp(768, 45, 1'b0, 1'b1, 4'h1, 4'h0));
    pulse_start1();
    wait_q1(2000);

    // Same delayed comparator with SETTLE=3 passes; 256*5 cycles.
    exp_q3.push_back(make_exp(1280, 0, 1'b1, 1'b0, 4'h0, 4'h0));
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    wait_q3(3000);

    // Reset in the middle of a failing sweep at vector 100 (A=4,B=6).
    mode = 1;
    pulse_start1();
    n = 0;
    while (!(a_ip1 == 4'h4 && b_ip1 == 4'h6) && n < 1000) begin @(negedge clk); n++; end
    check("reach_vector_100", 32'(n < 1000), 32'h1);
    check("err_before_reset", 32'(err_cnt1), 32'd27);
    #2 rst_n = 1'b0;
    #1 check_reset1("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_reset_busy", 32'(busy1), 32'h0);
    check("post_reset_done", 32'(done1), 32'h0);

    mode = 0;
    exp_q1.push_back(make_exp(768, 0, 1'b1, 1'b0, 4'h0, 4'h0));
    pulse_start1();
    wait_q1(2000);

    repeat (5) @(negedge clk);
    check("dut1_queue_drained", 32'(exp_q1.size()), 32'h0);
    check("dut3_queue_drained", 32'(exp_q3.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/signed_cmp_bist.md
SIGNED_CMP_BIST -- requirements
Module: signed_cmp_bist

Interface
REQ-001 Parameter: SETTLE, default 1, number of cycles between operand drive and result sample (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  single-cycle request to begin an exhaustive sweep.
REQ-005 a_ip  output  4  operand A driven to the comparator under test (two's complement).
REQ-006 b_ip  output  4  operand B driven to the comparator under test (two's complement).
REQ-007 a_ip_G, b_ip_G, a_ip_E_b  output  1 each  cascade inputs to the comparator, constant 0, 0, 1.
REQ-008 a_op_G, a_op_E_b, b_op_G  input  1 each  comparator results (A>B, A==B, B>A).
REQ-009 busy  output  1  sweep in progress.
REQ-010 done  output  1  sweep finished; held until next accepted start or reset.
REQ-011 pass  output  1  valid when done; 1 iff err_cnt == 0.
REQ-012 err_cnt  output  9  number of failing vectors in the current or last sweep.
REQ-013 fail_vld, fail_a, fail_b  output  1/4/4  first failing vector captured.

Function
REQ-014 FSM states: IDLE, APPLY, WAIT, CHECK, DONE.
REQ-015 IDLE --start--> APPLY; DONE --start--> APPLY; start in APPLY/WAIT/CHECK ignored.
REQ-016 Accepted start clears err_cnt, fail_vld, fail_a, fail_b, done, pass, and the 8-bit vector index.
REQ-017 Vector index {b,a}: b outer loop 0000..1111, a inner loop 0000..1111; 256 vectors total.
REQ-018 APPLY: a_ip/b_ip registered from index; one cycle, then WAIT.
REQ-019 WAIT: lasts SETTLE cycles exactly, counted by a 4-bit settle counter; then CHECK.
REQ-020 CHECK: sample a_op_G, a_op_E_b, b_op_G; compare against expected; one cycle.
REQ-021 Expected: signed(a_ip) > signed(b_ip) -> 100; equal -> 010; less -> 001 (order a_op_G, a_op_E_b, b_op_G).
REQ-022 Any deviation, including non-one-hot or all-zero results, counts as one error for that vector.
REQ-023 On error: err_cnt increments by 1 (max 256, no wrap); if fail_vld == 0, capture fail_a/fail_b and set fail_vld.
REQ-024 CHECK at index 255 -> DONE; otherwise index+1 -> APPLY; index does not wrap mid-sweep.
REQ-025 Sweep length: 256*(SETTLE+2) cycles from first APPLY to DONE entry.
REQ-026 busy = 1 in APPLY, WAIT, CHECK; 0 otherwise.
REQ-027 DONE: done = 1, pass = (err_cnt == 0); a_ip/b_ip hold last vector (1111/1111).
REQ-028 Cascade outputs constant in all states including reset.

Reset
REQ-029 rst_n low, at any time including mid-sweep: state IDLE immediately; a_ip=0000, b_ip=0000, busy=0, done=0, pass=0, err_cnt=0, fail_vld=0, fail_a=0000, fail_b=0000, index=0, settle counter=0.
REQ-030 After rst_n deasserts, no sweep begins without a new start.

Verification
REQ-031 Ideal signed comparator model, SETTLE=1, start pulse -> done after 768 cycles, pass=1, err_cnt=0, fail_vld=0.
REQ-032 a_op_G stuck at 0 -> err_cnt=120, pass=0, fail_vld=1, fail_a=0001, fail_b=0000.
REQ-033 Unsigned comparator substituted -> err_cnt=128, fail_a=1000, fail_b=0000.
REQ-034 SETTLE=3, comparator model with 3-cycle output delay -> pass=1; same model with SETTLE=1 -> pass=0.
REQ-035 rst_n low at vector 100 -> all outputs at reset values within same cycle; new start -> full clean 256-vector sweep, pass=1.
REQ-036 start pulsed while busy -> ignored, sweep length and results unchanged; start in DONE -> counters cleared, new sweep.
